// File: rtl/repeat4_seq_checker.sv
// Phase-locking checker for the repeat-4 up/down count stream (period 0..7..1, 15 entries).
// Optional macro REPEAT4_CHK_RESYNC_EN: re-anchor on a stray 0 or 7 while locked.
module repeat4_seq_checker #(
  parameter int MAX_MISS = 3,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [2:0]       cnt_in,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt,
  output logic [2:0]       expected,
  output logic             period_done
);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  localparam logic [3:0] LP_MAX_MISS = 4'(MAX_MISS);

  state_t             r_state, w_stateNext;
  logic [3:0]         r_idx, w_idxNext;
  logic [3:0]         r_miss, w_missNext;
  logic               r_err, w_errNext;
  logic               r_periodDone, w_periodDoneNext;
  logic [ERR_W-1:0]   r_errCnt, w_errCntNext;
  logic [2:0]         r_expected, w_expectedNext;
  logic [3:0]         w_idxInc;
  logic [3:0]         w_missInc;
  logic               w_resync;

  function automatic logic [2:0] goldenAt(input logic [3:0] idx);
    case (idx)
      4'd0:    goldenAt = 3'd0;
      4'd1:    goldenAt = 3'd1;
      4'd2:    goldenAt = 3'd2;
      4'd3:    goldenAt = 3'd3;
      4'd4:    goldenAt = 3'd4;
      4'd5:    goldenAt = 3'd5;
      4'd6:    goldenAt = 3'd6;
      4'd7:    goldenAt = 3'd7;
      4'd8:    goldenAt = 3'd6;
      4'd9:    goldenAt = 3'd5;
      4'd10:   goldenAt = 3'd4;
      4'd11:   goldenAt = 3'd4;
      4'd12:   goldenAt = 3'd3;
      4'd13:   goldenAt = 3'd2;
      4'd14:   goldenAt = 3'd1;
      default: goldenAt = 3'd0;
    endcase
  endfunction

`ifdef REPEAT4_CHK_RESYNC_EN
  assign w_resync = (cnt_in == 3'd0) || (cnt_in == 3'd7);
`else
  assign w_resync = 1'b0;
`endif

  assign w_idxInc  = (r_idx == 4'd14) ? 4'd0 : r_idx + 4'd1;
  assign w_missInc = r_miss + 4'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= HUNT;
      r_idx        <= 4'd0;
      r_miss       <= 4'd0;
      r_err        <= 1'b0;
      r_periodDone <= 1'b0;
      r_errCnt     <= '0;
      r_expected   <= 3'd0;
    end else begin
      r_state      <= w_stateNext;
      r_idx        <= w_idxNext;
      r_miss       <= w_missNext;
      r_err        <= w_errNext;
      r_periodDone <= w_periodDoneNext;
      r_errCnt     <= w_errCntNext;
      r_expected   <= w_expectedNext;
    end
  end

  always_comb begin
    w_stateNext      = r_state;
    w_idxNext        = r_idx;
    w_missNext       = r_miss;
    w_errNext        = 1'b0;
    w_periodDoneNext = 1'b0;
    w_errCntNext     = r_errCnt;
    w_expectedNext   = r_expected;
    if (r_idx == 4'd15) begin
      // Corrupted index can never be trusted; fall back and re-acquire.
      w_stateNext    = HUNT;
      w_idxNext      = 4'd0;
      w_missNext     = 4'd0;
      w_expectedNext = 3'd0;
    end else if (in_valid) begin
      case (r_state)
        HUNT: begin
          if (cnt_in == 3'd0) begin
            w_stateNext = LOCKED;
            w_idxNext   = 4'd1;
          end else if (cnt_in == 3'd7) begin
            w_stateNext = LOCKED;
            w_idxNext   = 4'd8;
          end
        end
        LOCKED: begin
          if (cnt_in == goldenAt(r_idx)) begin
            w_idxNext        = w_idxInc;
            w_missNext       = 4'd0;
            w_periodDoneNext = (r_idx == 4'd14);
          end else begin
            w_errNext = 1'b1;
            if (!(&r_errCnt))
              w_errCntNext = r_errCnt + 1'b1;
            if (w_resync) begin
              w_idxNext  = (cnt_in == 3'd0) ? 4'd1 : 4'd8;
              w_missNext = 4'd0;
            end else if (w_missInc >= LP_MAX_MISS) begin
              w_stateNext = HUNT;
              w_idxNext   = 4'd0;
              w_missNext  = 4'd0;
            end else begin
              w_idxNext  = w_idxInc;
              w_missNext = w_missInc;
            end
          end
        end
        default: begin
          w_stateNext = HUNT;
          w_idxNext   = 4'd0;
          w_missNext  = 4'd0;
        end
      endcase
      w_expectedNext = (w_stateNext == LOCKED) ? goldenAt(w_idxNext) : 3'd0;
    end
  end

  assign locked      = (r_state == LOCKED);
  assign err         = r_err;
  assign err_cnt     = r_errCnt;
  assign expected    = r_expected;
  assign period_done = r_periodDone;

endmodule

// File: tb/tb_repeat4_seq_checker.sv
// Directed scoreboard bench for repeat4_seq_checker; a second instance with ERR_W=2 checks saturation.
module tb_repeat4_seq_checker;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [2:0] cnt_in;
  logic       locked, err, period_done;
  logic [7:0] err_cnt;
  logic [2:0] expected;
  logic       lockedS, errS, periodDoneS;
  logic [1:0] errCntS;
  logic [2:0] expectedS;

  repeat4_seq_checker #(.MAX_MISS(3), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .cnt_in(cnt_in),
    .locked(locked), .err(err), .err_cnt(err_cnt), .expected(expected),
    .period_done(period_done)
  );

  repeat4_seq_checker #(.MAX_MISS(3), .ERR_W(2)) dutSat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .cnt_in(cnt_in),
    .locked(lockedS), .err(errS), .err_cnt(errCntS), .expected(expectedS),
    .period_done(periodDoneS)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       l;
    logic       e;
    logic [7:0] c8;
    logic [1:0] c2;
    logic [2:0] x;
    logic       pd;
  } exp_t;

  exp_t sbQ[$];
  int   golden[15] = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 4, 3, 2, 1};
  int   nChecks = 0;
  int   nFail = 0;
  int   pdSeen = 0;

  // Reference model state
  bit   mLocked;
  int   mIdx;
  int   mMiss;
  int   mCnt8;
  int   mCnt2;

  task automatic checkField(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mLocked = 1'b0;
    mIdx    = 0;
    mMiss   = 0;
    mCnt8   = 0;
    mCnt2   = 0;
  endtask

  task automatic modelStep(input logic v, input logic [2:0] d, output exp_t r);
    r.e  = 1'b0;
    r.pd = 1'b0;
    if (v) begin
      if (!mLocked) begin
        if (d == 3'd0) begin
          mLocked = 1'b1;
          mIdx    = 1;
        end else if (d == 3'd7) begin
          mLocked = 1'b1;
          mIdx    = 8;
        end
      end else if (int'(d) == golden[mIdx]) begin
        if (mIdx == 14) r.pd = 1'b1;
        mIdx  = (mIdx + 1) % 15;
        mMiss = 0;
      end else begin
        r.e = 1'b1;
        if (mCnt8 < 255) mCnt8++;
        if (mCnt2 < 3) mCnt2++;
`ifdef REPEAT4_CHK_RESYNC_EN
        if (d == 3'd0 || d == 3'd7) begin
          mIdx  = (d == 3'd0) ? 1 : 8;
          mMiss = 0;
        end else begin
`else
        begin
`endif
          mIdx = (mIdx + 1) % 15;
          mMiss++;
          if (mMiss >= 3) begin
            mLocked = 1'b0;
            mIdx    = 0;
            mMiss   = 0;
          end
        end
      end
    end
    r.l  = mLocked;
    r.c8 = 8'(mCnt8);
    r.c2 = 2'(mCnt2);
    r.x  = mLocked ? 3'(golden[mIdx]) : 3'd0;
  endtask

  task automatic checkOutput();
    exp_t r;
    if (sbQ.size() == 0) begin
      nChecks++;
      nFail++;
      $error("[TB] FAIL scoreboard: observed empty queue expected entry");
      return;
    end
    r = sbQ.pop_front();
    if (period_done === 1'b1) pdSeen++;
    checkField("locked", 8'(locked), 8'(r.l));
    checkField("err", 8'(err), 8'(r.e));
    checkField("err_cnt", err_cnt, r.c8);
    checkField("expected", 8'(expected), 8'(r.x));
    checkField("period_done", 8'(period_done), 8'(r.pd));
    checkField("sat_locked", 8'(lockedS), 8'(r.l));
    checkField("sat_err_cnt", 8'(errCntS), 8'(r.c2));
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] d);
    exp_t r;
    @(negedge clk);
    in_valid = v;
    cnt_in   = d;
    modelStep(v, d, r);
    sbQ.push_back(r);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic feedGolden(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 3'(golden[mIdx]));
  endtask

  task automatic feedWrong();
    logic [2:0] w;
    w = (golden[mIdx] == 3) ? 3'd4 : 3'd3;
    applyStimulus(1'b1, w);
  endtask

  // Reset asserted between clock edges must clear every output without a clock.
  task automatic asyncReset(input string tag);
    #3;
    rst = 1'b0;
    #1;
    checkField({tag, "_locked"}, 8'(locked), 8'd0);
    checkField({tag, "_err"}, 8'(err), 8'd0);
    checkField({tag, "_err_cnt"}, err_cnt, 8'd0);
    checkField({tag, "_expected"}, 8'(expected), 8'd0);
    checkField({tag, "_period_done"}, 8'(period_done), 8'd0);
    checkField({tag, "_sat_err_cnt"}, 8'(errCntS), 8'd0);
    modelReset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst      = 1'b0;
    in_valid = 1'b0;
    cnt_in   = 3'd0;
    modelReset();
    #2;
    checkField("rst_locked", 8'(locked), 8'd0);
    checkField("rst_err_cnt", err_cnt, 8'd0);
    checkField("rst_expected", 8'(expected), 8'd0);
    @(negedge clk);
    rst = 1'b1;

    // Two clean periods starting at the 0 anchor
    for (int i = 0; i < 30; i++) applyStimulus(1'b1, 3'(golden[i % 15]));
    checkField("pd_count_two_periods", 8'(pdSeen), 8'd2);

    asyncReset("midreset");

    // Mid-period start: hunt through 3..6, lock on 7, one bad 4 at idx 10
    applyStimulus(1'b1, 3'd3);
    applyStimulus(1'b1, 3'd4);
    applyStimulus(1'b1, 3'd5);
    applyStimulus(1'b1, 3'd6);
    applyStimulus(1'b1, 3'd7);
    applyStimulus(1'b1, 3'd6);
    applyStimulus(1'b1, 3'd5);
    applyStimulus(1'b1, 3'd5);
    applyStimulus(1'b1, 3'd4);
    feedGolden(4);

    // Three consecutive misses drop lock, then re-lock on 7
    feedWrong();
    feedWrong();
    feedWrong();
    applyStimulus(1'b1, 3'd1);
    applyStimulus(1'b1, 3'd7);
    feedGolden(3);

    // Qualifier gap: garbage data must be ignored
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 3'd5);
    feedGolden(6);

    asyncReset("satreset");

    // Five locked mismatches without reaching the drop threshold
    applyStimulus(1'b1, 3'd0);
    feedWrong();
    feedWrong();
    feedGolden(1);
    feedWrong();
    feedWrong();
    feedGolden(1);
    feedWrong();
    checkField("sat_final", 8'(errCntS), 8'd3);
    checkField("wide_final", err_cnt, 8'd5);

    // Stray 0 while locked away from idx 0
    feedGolden(3);
    applyStimulus(1'b1, 3'd0);
    feedGolden(3);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/repeat4_seq_checker.md
Name: repeat4_seq_checker

Overview:
- Receive-side checker for the repeat-4 up/down counter stream. Golden 15-entry period: 0,1,2,3,4,5,6,7,6,5,4,4,3,2,1, then wraps to 0.
- Samples a 3-bit count on qualified cycles, acquires phase lock on the stream, then compares every later sample against the golden sequence.
- Reports lock status, per-sample error pulses, a saturating error count and period-complete pulses.
- Sits downstream of the counter (or across a link carrying it) as a self-check and monitor block.

Parameters:
- MAX_MISS, 3: consecutive mismatches in LOCKED that force a drop back to HUNT. Legal range 1..15.
- ERR_W, 8: width of err_cnt.

Ports:
- clk  input  1  single clock, all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  sample qualifier; cnt_in is ignored when low.
- cnt_in  input  3  count value under check.
- locked  output  1  high while FSM is in LOCKED.
- err  output  1  one-cycle pulse: the last valid sample in LOCKED mismatched.
- err_cnt  output  ERR_W  total mismatches since reset; saturates at all-ones.
- expected  output  3  golden value expected for the next valid sample; 0 in HUNT.
- period_done  output  1  one-cycle pulse when a matching sample of 1 completes the period (index 14 -> 0).

Behaviour:
- Reset (rst=0, asynchronous): state HUNT, idx=0, miss=0. Outputs locked=0, err=0, err_cnt=0, expected=0, period_done=0.
- All outputs are registered. Response appears the cycle after the valid sample.
- in_valid=0: state, idx, miss, expected and err_cnt hold. err and period_done are 0.
- Golden ROM index 0..14 holds 0,1,2,3,4,5,6,7,6,5,4,4,3,2,1.
- Only 0 (idx 0) and 7 (idx 7) are unique in the period, so they are the only legal anchors.
- HUNT:
  - Valid sample 0 -> LOCKED, idx=1, expected=1.
  - Valid sample 7 -> LOCKED, idx=8, expected=6.
  - Any other value stays in HUNT.
  - No errors are counted in HUNT.
- LOCKED, valid sample equal to golden[idx]:
  - idx advances to (idx==14) ? 0 : idx+1.
  - miss clears.
  - period_done pulses if idx was 14.
- LOCKED, valid sample not equal to golden[idx]:
  - err pulses; err_cnt increments unless saturated.
  - idx still advances (flywheel); miss increments.
  - If miss reaches MAX_MISS: go to HUNT, idx=0, miss=0, expected=0, locked=0 on the following cycle.
  - The sample that causes the drop is not also used as a HUNT anchor.
- expected always equals golden[idx] in LOCKED.
- Width rules:
  - idx is 4 bits; values 15 are unreachable and any such value forces HUNT.
  - miss is 4 bits.
  - err_cnt never wraps.
- Reset asserted mid-stream: immediate return to reset values. Lock must be re-acquired from an anchor.

Optional Feature:
- Macro: REPEAT4_CHK_RESYNC_EN.
- Defined: in LOCKED, a mismatching valid sample equal to 0 or 7 still pulses err and increments err_cnt.
  - It immediately re-anchors: idx=1 for sample 0, idx=8 for sample 7.
  - miss clears; state stays LOCKED.
- Not defined: no re-anchoring in LOCKED. Flywheel and MAX_MISS drop are the only recovery path.

Test Plan:
- Reset, then feed two clean periods starting at 0 with in_valid=1 every cycle.
  - Required: locked=1 the cycle after the first 0; err never pulses; err_cnt=0.
  - Required: period_done pulses exactly twice, each the cycle after a sample of 1 at idx 14.
- Start the stream mid-period at 3,4,5,6,7,6,...
  - Required: HUNT persists through 3..6; lock is taken on 7 with expected=6.
  - Required: the next sample 6 matches and the following sample 5 matches.
- While locked, replace one 4 (idx 10) with 5.
  - Required: a single err pulse; err_cnt=1; locked stays 1; the next 4 at idx 11 matches and miss clears.
- Inject 3 consecutive wrong values with MAX_MISS=3.
  - Required: three err pulses, err_cnt=3, locked=0 after the third.
  - Required: re-lock on the next 0 or 7.
- Toggle in_valid low for 5 cycles mid-period, then resume the correct sequence.
  - Required: no err and no index advance during the gap; matching resumes.
  - Separately, assert rst mid-stream: all outputs read 0 asynchronously.
- Force ERR_W=2 and run 5 mismatches.
  - Required: err_cnt saturates at 3.
  - Required: with REPEAT4_CHK_RESYNC_EN defined, a stray 0 while locked re-anchors to idx 1 without dropping lock.
